// File: rtl/fu_pkg.sv
// Shared FU interface definitions: payload field widths, the packed payload
// record carried from the reservation station to any functional unit, and
// its reset/default value. FU wrappers and fu_dispatch import this package
// so there is one definition of the payload layout.
package fu_pkg;

   localparam int unsigned FU_INST_ID_BITS = 6;
   localparam int unsigned FU_PRN_BITS     = 6;
   localparam int unsigned FU_MAX_OPERANDS = 3;
   localparam int unsigned FU_INST_BITS    = 32;
   localparam int unsigned FU_PC_BITS      = 64;
   localparam int unsigned FU_OP_BITS      = 64;

   typedef struct packed {
      logic [FU_INST_ID_BITS-1:0]                    inst_id;
      logic [FU_INST_BITS-1:0]                       inst;
      logic [FU_PC_BITS-1:0]                         pc;
      logic [FU_MAX_OPERANDS-1:0][FU_OP_BITS-1:0]    op;
      logic [FU_MAX_OPERANDS-1:0][FU_PRN_BITS-1:0]   out_prn;
   } fu_payload_t;

   localparam fu_payload_t FU_PAYLOAD_DEFAULT = '0;

endpackage

// File: rtl/fu_payload_fifo.sv
// In-order synchronous FIFO of fu_payload_t entries.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   flush        synchronous clear (head=tail, count=0)
//   push, wdata  write wdata at tail (ignored when full)
//   pop          advance head (ignored when empty)
//   rdata        current head entry (stale/default when empty)
//   full, empty  occupancy flags derived from the registered count
module fu_payload_fifo
   import fu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push,
   input  fu_payload_t wdata,
   input  logic        pop,
   output fu_payload_t rdata,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

   fu_payload_t         mem [DEPTH];
   logic [PTR_BITS-1:0] head;
   logic [PTR_BITS-1:0] tail;
   logic [CNT_BITS-1:0] count;
   logic                push_en;
   logic                pop_en;

   // Count is one bit wider than the pointers so full and empty differ.
   assign full    = (count == CNT_BITS'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rdata   = mem[head];

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_en) tail <= tail + PTR_BITS'(1);
         if (pop_en)  head <= head + PTR_BITS'(1);
         if (push_en && !pop_en)      count <= count + CNT_BITS'(1);
         else if (pop_en && !push_en) count <= count - CNT_BITS'(1);
      end
   end

   // Storage; cleared on reset so the head payload reads as zero afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[PTR_BITS'(i)] <= FU_PAYLOAD_DEFAULT;
      end else if (push_en && !flush) begin
         mem[tail] <= wdata;
      end
   end

endmodule

// File: rtl/fu_dispatch.sv
// Issue-side initiator for one functional unit. Buffers ready instructions
// from the reservation station, presents the oldest to the FU, and throttles
// issue once MAX_INFLIGHT instructions are outstanding.
// INST_ID_BITS/PRN_BITS/MAX_OPERANDS must match the fu_pkg payload widths.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous flush: drops queue and outstanding count
//   rs_valid/rs_ready   RS handshake; rs_* payload written on acceptance
//   inst_valid          issue strobe (head pops on every cycle it is high)
//   inst_id..out_prn    head entry payload
//   fu_ready            FU can take an instruction this cycle
//   fu_out_valid        FU completion pulse
//   inflight            issued-but-uncompleted count
//   empty               queue holds no entries
//   err_underflow       sticky: completion seen with nothing outstanding
module fu_dispatch
   import fu_pkg::*;
#(
   parameter int unsigned INST_ID_BITS = FU_INST_ID_BITS,
   parameter int unsigned PRN_BITS     = FU_PRN_BITS,
   parameter int unsigned MAX_OPERANDS = FU_MAX_OPERANDS,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic                                  rs_valid,
   output logic                                  rs_ready,
   input  logic [INST_ID_BITS-1:0]               rs_inst_id,
   input  logic [31:0]                           rs_inst,
   input  logic [63:0]                           rs_pc,
   input  logic [63:0]                           rs_op      [MAX_OPERANDS],
   input  logic [PRN_BITS-1:0]                   rs_out_prn [MAX_OPERANDS],
   output logic                                  inst_valid,
   output logic [INST_ID_BITS-1:0]               inst_id,
   output logic [31:0]                           inst,
   output logic [63:0]                           pc,
   output logic [63:0]                           op         [MAX_OPERANDS],
   output logic [PRN_BITS-1:0]                   out_prn    [MAX_OPERANDS],
   input  logic                                  fu_ready,
   input  logic                                  fu_out_valid,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
   output logic                                  empty,
   output logic                                  err_underflow
);

   localparam int unsigned IF_BITS = $clog2(MAX_INFLIGHT + 1);

   fu_payload_t wdata;
   fu_payload_t rdata;
   logic        fifo_full;
   logic        fifo_empty;

   // Pack RS payload into the FIFO record and unpack the head for the FU.
   assign wdata.inst_id = rs_inst_id;
   assign wdata.inst    = rs_inst;
   assign wdata.pc      = rs_pc;
   assign inst_id       = rdata.inst_id;
   assign inst          = rdata.inst;
   assign pc            = rdata.pc;

   for (genvar k = 0; k < MAX_OPERANDS; k++) begin : g_slot
      assign wdata.op[k]      = rs_op[k];
      assign wdata.out_prn[k] = rs_out_prn[k];
      assign op[k]            = rdata.op[k];
      assign out_prn[k]       = rdata.out_prn[k];
   end

   // Handshakes: no pop-to-push pass-through, so full alone blocks the RS.
   assign rs_ready   = !fifo_full && !flush;
   assign inst_valid = !fifo_empty && fu_ready && !flush &&
                       (inflight < IF_BITS'(MAX_INFLIGHT));
   assign empty      = fifo_empty;

   fu_payload_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (rs_valid && rs_ready),
      .wdata (wdata),
      .pop   (inst_valid),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Outstanding count; completions on a flush cycle are dropped, and a
   // completion with nothing outstanding leaves the count at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight      <= '0;
         err_underflow <= 1'b0;
      end else if (flush) begin
         inflight <= '0;
      end else begin
         if (inst_valid && !fu_out_valid) begin
            inflight <= inflight + IF_BITS'(1);
         end else if (fu_out_valid && !inst_valid && (inflight != '0)) begin
            inflight <= inflight - IF_BITS'(1);
         end
         if (fu_out_valid && (inflight == '0)) err_underflow <= 1'b1;
      end
   end

endmodule
